sdcard_multi_reader: RTL and testbench

Parametrised multi-block SD read engine. Sits between application logic and the low-level SPI SD controller (sd_controller). It computes the sector address from region/block indices and reads N consecutive 512-byte blocks. Data is streamed out as packed words over a valid/ready interface rather than one wide block register. Adds backpressure, per-byte timeout, abort and error reporting.

---
 rtl/sdcard_pkg.sv | 28 ++
 rtl/sdcard_multi_reader_if.sv | 33 +++
 rtl/sd_byte_packer.sv | 67 ++++++
 rtl/sdcard_multi_reader.sv | 133 +++++++++++++
 tb/tb_sdcard_multi_reader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdcard_pkg.sv
// Shared types and constants for the multi-block SD read engine.
package sdcard_pkg;

    localparam int SD_BLOCK_BYTES = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CTRL,
        ST_STREAM,
        ST_BLK_END,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CTRL    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_code_t;

    // Resolves simultaneous fault sources; only called when at least one is active.
    function automatic err_code_t pick_err(input logic ctrl_hit, input logic tmo_hit);
        if (ctrl_hit) return ERR_CTRL;
        if (tmo_hit)  return ERR_TIMEOUT;
        return ERR_ABORT;
    endfunction

endpackage

// File: rtl/sdcard_multi_reader_if.sv
// Application-side request and word-stream bus of the SD multi-block reader.
interface sdcard_multi_reader_if
    import sdcard_pkg::*;
#(
    parameter int ID_W       = 10,
    parameter int NBLK_W     = 8,
    parameter int WORD_BYTES = 4
) ();
    logic                    req;
    logic                    req_ready;
    logic [ID_W-1:0]         img_id;
    logic [ID_W-1:0]         block_id;
    logic [NBLK_W-1:0]       nblocks;
    logic                    abort;
    logic [8*WORD_BYTES-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last_blk;
    logic                    m_last;
    logic                    done;
    logic                    err;
    err_code_t               err_code;

    modport master (
        output req, img_id, block_id, nblocks, abort, m_ready,
        input  req_ready, m_data, m_valid, m_last_blk, m_last, done, err, err_code
    );

    modport slave (
        input  req, img_id, block_id, nblocks, abort, m_ready,
        output req_ready, m_data, m_valid, m_last_blk, m_last, done, err, err_code
    );
endinterface

// File: rtl/sd_byte_packer.sv
// Packs bytes (first byte in the low lane) into words with a one-word holding register.
module sd_byte_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [7:0]              in_byte,
    input  logic                    in_last_blk,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last_blk,
    output logic                    out_last,
    output logic                    empty
);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_BYTES - 1);

    logic [CNT_W-1:0]        cnt;
    logic [8*WORD_BYTES-1:0] acc, word_nx, hold_q;
    logic                    valid_q, last_blk_q, last_q;

    always_comb begin
        word_nx = acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (cnt == CNT_W'(i)) word_nx[i*8 +: 8] = in_byte;
        end
    end

    // A byte may complete a word only if the holding register is free or draining now.
    assign in_ready     = !valid_q || out_ready;
    assign out_data     = hold_q;
    assign out_valid    = valid_q;
    assign out_last_blk = last_blk_q;
    assign out_last     = last_q;
    assign empty        = (cnt == '0) && !valid_q;

    always_ff @(posedge CLOCK_50) begin
        // NOTE: the data registers are reset as well so m_data reads 0 after reset or flush.
        if (RESET || flush) begin
            cnt        <= '0;
            acc        <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            last_blk_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (valid_q && out_ready) valid_q <= 1'b0;
            if (in_valid) begin
                if (cnt == CNT_MAX) begin
                    hold_q     <= word_nx;
                    last_blk_q <= in_last_blk;
                    last_q     <= in_last;
                    valid_q    <= 1'b1;
                    cnt        <= '0;
                end else begin
                    acc <= word_nx;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sdcard_multi_reader.sv
// Multi-block SD read engine: sector addressing, byte handshake with sd_controller,
// word packing with backpressure, timeout/abort/error reporting.
module sdcard_multi_reader
    import sdcard_pkg::*;
#(
    parameter logic [31:0] BASE_SECTOR    = 32'd24832,
    parameter logic [31:0] IMG_STRIDE     = 32'd856,
    parameter int          ID_W           = 10,
    parameter int          NBLK_W         = 8,
    parameter int          WORD_BYTES     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
    parameter logic [7:0]  CTRL_IDLE_CODE = 8'h11
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    sdcard_multi_reader_if.slave app,
    output logic                 ctl_rd,
    output logic [31:0]          ctl_addr,
    output logic                 ctl_dout_taken,
    input  logic [7:0]           ctl_dout,
    input  logic                 ctl_dout_avail,
    input  logic                 ctl_busy,
    input  logic                 ctl_error,
    input  logic [7:0]           ctl_fsm
);
    localparam logic [9:0] LAST_BYTE = 10'(SD_BLOCK_BYTES - 1);

    state_t            state, state_nx;
    err_code_t         err_code_q;
    logic [31:0]       addr_q, tmo_cnt;
    logic [NBLK_W-1:0] nblk_q, k_q, k_inc;
    logic [9:0]        byte_cnt;
    logic [ID_W-1:0]   img_s, blk_s;
    logic              taken_q, take, accept, active, done;
    logic              ctrl_hit, tmo_hit, abort_hit, fault;
    logic              pk_flush, pk_in_ready, pk_empty, byte_last_blk, byte_last;

    assign img_s  = app.img_id;
    assign blk_s  = app.block_id;
    assign k_inc  = k_q + 1'b1;
    assign accept = app.req && (state == ST_IDLE);
    assign active = (state == ST_WAIT_CTRL) || (state == ST_STREAM);

    // Abort is ignored once a fault is latched, so a held abort cannot starve done.
    assign ctrl_hit  = active && ctl_error;
    assign tmo_hit   = active && (tmo_cnt >= TIMEOUT_CYCLES);
    assign abort_hit = app.abort && (state != ST_IDLE) && (err_code_q == ERR_NONE);
    assign fault     = ctrl_hit || tmo_hit || abort_hit;

    assign byte_last_blk = (byte_cnt == LAST_BYTE);
    assign byte_last     = byte_last_blk && (k_inc == nblk_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_nx = state;
        take     = 1'b0;
        pk_flush = 1'b0;
        case (state)
            ST_IDLE:      if (accept) state_nx = (app.nblocks == '0) ? ST_FINISH : ST_WAIT_CTRL;
            ST_WAIT_CTRL: if (ctl_fsm == CTRL_IDLE_CODE && !ctl_busy) state_nx = ST_STREAM;
            ST_STREAM: begin
                take = ctl_dout_avail && !taken_q && pk_in_ready;
                if (take && byte_last_blk) state_nx = ST_BLK_END;
            end
            ST_BLK_END:   state_nx = (k_inc == nblk_q) ? ST_FINISH : ST_WAIT_CTRL;
            ST_FINISH:    if (pk_empty) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
        if (fault) begin
            take     = 1'b0;
            pk_flush = 1'b1;
            state_nx = ST_FINISH;
        end
        done = (state == ST_FINISH) && pk_empty && !fault;
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RESET) begin
            state      <= ST_IDLE;
            addr_q     <= BASE_SECTOR;
            nblk_q     <= '0;
            k_q        <= '0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            err_code_q <= ERR_NONE;
            taken_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            taken_q <= take;
            tmo_cnt <= (state_nx != state || take || !active) ? 32'd0 : tmo_cnt + 32'd1;
            if (take) byte_cnt <= byte_cnt + 10'd1;
            if (accept) begin
                addr_q     <= BASE_SECTOR + 32'(img_s) * IMG_STRIDE + 32'(blk_s);
                nblk_q     <= app.nblocks;
                k_q        <= '0;
                byte_cnt   <= '0;
                err_code_q <= ERR_NONE;
            end
            if (state == ST_BLK_END) begin
                k_q      <= k_inc;
                addr_q   <= addr_q + 32'd1;
                byte_cnt <= '0;
            end
            if (fault) err_code_q <= pick_err(ctrl_hit, tmo_hit);
        end
    end

    sd_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .flush        (pk_flush),
        .in_valid     (take),
        .in_byte      (ctl_dout),
        .in_last_blk  (byte_last_blk),
        .in_last      (byte_last),
        .in_ready     (pk_in_ready),
        .out_data     (app.m_data),
        .out_valid    (app.m_valid),
        .out_ready    (app.m_ready),
        .out_last_blk (app.m_last_blk),
        .out_last     (app.m_last),
        .empty        (pk_empty)
    );

    assign ctl_rd         = (state == ST_STREAM);
    assign ctl_addr       = addr_q;
    assign ctl_dout_taken = taken_q;
    assign app.req_ready  = (state == ST_IDLE);
    assign app.done       = done;
    assign app.err        = done && (err_code_q != ERR_NONE);
    assign app.err_code   = err_code_q;
endmodule

// File: tb/tb_sdcard_multi_reader.sv
// Randomized bench for sdcard_multi_reader: behavioural SD controller, consumer and word scoreboard.
module tb_sdcard_multi_reader;
    import sdcard_pkg::*;

    localparam int          WB     = 4;
    localparam int          WPB    = SD_BLOCK_BYTES / WB;
    localparam logic [31:0] BASE   = 32'd24832;
    localparam logic [31:0] STRIDE = 32'd856;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       ctl_rd, ctl_dout_taken, ctl_dout_avail, ctl_busy, ctl_error;
    logic [31:0] ctl_addr;
    logic [7:0] ctl_dout, ctl_fsm;

    sdcard_multi_reader_if #(.ID_W(10), .NBLK_W(8), .WORD_BYTES(WB)) app ();

    sdcard_multi_reader #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(32'd100)) dut (
        .CLOCK_50       (CLOCK_50),
        .RESET          (RESET),
        .app            (app),
        .ctl_rd         (ctl_rd),
        .ctl_addr       (ctl_addr),
        .ctl_dout_taken (ctl_dout_taken),
        .ctl_dout       (ctl_dout),
        .ctl_dout_avail (ctl_dout_avail),
        .ctl_busy       (ctl_busy),
        .ctl_error      (ctl_error),
        .ctl_fsm        (ctl_fsm)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus pattern: byte i of block b within a request.
    function automatic logic [7:0] byte_at(input int s, input int b, input int i);
        return 8'(i + s + b * 37);
    endfunction

    // Expected word as {m_last, m_last_blk, m_data}.
    function automatic logic [33:0] exp_word(input int s, input int b, input int w, input int n);
        logic [31:0] d;
        logic        lb;
        for (int j = 0; j < WB; j++) d[j*8 +: 8] = byte_at(s, b, w * WB + j);
        lb = (w == WPB - 1);
        return {lb && (b == n - 1), lb, d};
    endfunction

    logic [33:0] exp_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] got_addr[$];
    int  exp_total, word_cnt, proto_err;
    int  salt, cm_idx, cm_gap, cm_blk, cons_mode, stall_left, since;
    bit  hung, in_stream, abort_arm;
    bit  prev_rd, prev_taken, prev_stall, prev_abort;
    logic [33:0] prev_word;

    // Controller model, consumer, monitors: all act on the falling edge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (RESET) begin
                in_stream = 0; ctl_dout_avail = 0; ctl_busy = 0; ctl_fsm = 8'h11;
                prev_rd = 0; prev_taken = 0; prev_stall = 0; prev_abort = 0; stall_left = 0;
            end else begin
                if (ctl_dout_taken && (prev_taken || prev_stall)) proto_err++;
                if (prev_stall && !prev_abort &&
                    (!app.m_valid || {app.m_last, app.m_last_blk, app.m_data} != prev_word)) proto_err++;
                if (ctl_rd && !prev_rd) got_addr.push_back(ctl_addr);

                if (app.abort) begin
                    app.abort = 1'b0;
                    check("abort_rd_drop", ctl_rd, 0);
                    check("abort_flush", app.m_valid, 0);
                end else if (abort_arm && in_stream && cm_blk == 1 && cm_idx == 300) begin
                    app.abort = 1'b1;
                    abort_arm = 0;
                end

                if (hung) begin
                    ctl_fsm = 8'h00; ctl_busy = 0; ctl_dout_avail = 0;
                end else if (!in_stream) begin
                    ctl_fsm = 8'h11; ctl_busy = 0; ctl_dout_avail = 0;
                    if (ctl_rd) begin
                        in_stream = 1; cm_idx = 0; cm_gap = $urandom_range(0, 3);
                        ctl_fsm = 8'h05; ctl_busy = 1;
                    end
                end else begin
                    if (ctl_dout_taken) begin
                        ctl_dout_avail = 0; cm_idx++; cm_gap = $urandom_range(0, 2);
                    end
                    if (!ctl_rd) begin
                        in_stream = 0; ctl_dout_avail = 0; ctl_fsm = 8'h11; ctl_busy = 0;
                        if (cm_idx == SD_BLOCK_BYTES) cm_blk++;
                    end else if (!ctl_dout_avail && cm_idx < SD_BLOCK_BYTES) begin
                        if (cm_gap == 0) begin
                            ctl_dout = byte_at(salt, cm_blk, cm_idx);
                            ctl_dout_avail = 1;
                        end else cm_gap--;
                    end
                end

                case (cons_mode)
                    0: app.m_ready = 1'b1;
                    1: app.m_ready = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (stall_left > 0) begin app.m_ready = 1'b0; stall_left--; end
                        else app.m_ready = 1'b1;
                    end
                endcase
                if (app.m_valid && app.m_ready) begin
                    word_cnt++;
                    if (exp_q.size() == 0) check("word_count", word_cnt, exp_total);
                    else check("word", {app.m_last, app.m_last_blk, app.m_data}, exp_q.pop_front());
                    since++;
                    if (since == 7) begin since = 0; if (cons_mode == 2) stall_left = 20; end
                end

                prev_rd    = ctl_rd;
                prev_taken = ctl_dout_taken;
                prev_stall = app.m_valid && !app.m_ready;
                prev_word  = {app.m_last, app.m_last_blk, app.m_data};
                prev_abort = app.abort;
            end
        end
    end

    task automatic start_req(input int img, input int blk, input int n, input int s);
        int tries;
        exp_q.delete(); exp_addr.delete(); got_addr.delete();
        word_cnt = 0; exp_total = n * WPB; cm_blk = 0; cm_idx = 0; salt = s;
        for (int b = 0; b < n; b++) begin
            exp_addr.push_back(BASE + 32'(img) * STRIDE + 32'(blk) + 32'(b));
            for (int w = 0; w < WPB; w++) exp_q.push_back(exp_word(s, b, w, n));
        end
        tries = 0;
        @(negedge CLOCK_50);
        while (!app.req_ready && tries < 100) begin @(negedge CLOCK_50); tries++; end
        check("req_ready", app.req_ready, 1);
        app.req = 1'b1; app.img_id = 10'(img); app.block_id = 10'(blk); app.nblocks = 8'(n);
        @(negedge CLOCK_50);
        app.req = 1'b0;
    endtask

    task automatic run_req(input int img, input int blk, input int n, input int s,
                           input int exp_code, input int exp_cycles);
        int cycles;
        start_req(img, blk, n, s);
        cycles = 0;
        while (!app.done && cycles < 20000) begin @(negedge CLOCK_50); cycles++; end
        check("done_seen", app.done, 1);
        check("err", app.err, exp_code != 0);
        check("err_code", app.err_code, exp_code);
        if (exp_cycles >= 0) check("done_cycle", cycles, exp_cycles);
        @(negedge CLOCK_50);
        check("done_pulse", app.done, 0);
        check("err_code_held", app.err_code, exp_code);
        check("taken_protocol", proto_err, 0);
        if (exp_code == 0) begin
            check("words_left", exp_q.size(), 0);
            check("blk_count", got_addr.size(), exp_addr.size());
            for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
                check("addr", got_addr[i], exp_addr[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, app.req_ready, 1);
        check({tag, "_m_valid"}, app.m_valid, 0);
        check({tag, "_m_data"}, app.m_data, 0);
        check({tag, "_flags"}, {app.m_last, app.m_last_blk, app.done, app.err}, 0);
        check({tag, "_err_code"}, app.err_code, 0);
        check({tag, "_ctl_rd"}, ctl_rd, 0);
        check({tag, "_taken"}, ctl_dout_taken, 0);
        check({tag, "_ctl_addr"}, ctl_addr, BASE);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dcnt;
        app.req = 0; app.img_id = 0; app.block_id = 0; app.nblocks = 0; app.abort = 0; app.m_ready = 1;
        ctl_dout = 0; ctl_dout_avail = 0; ctl_busy = 0; ctl_error = 0; ctl_fsm = 8'h11;
        hung = 0; abort_arm = 0; cons_mode = 0; proto_err = 0; since = 0; salt = 0;
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("reset");
        RESET = 1'b0;

        // Single block at img 2 / block 5, counting byte pattern.
        run_req(2, 5, 1, 0, 0, -1);
        if (got_addr.size() > 0) check("addr_t1", got_addr[0], 32'd26549);

        // Three consecutive blocks with random backpressure.
        cons_mode = 1;
        run_req(0, 0, 3, $urandom_range(0, 255), 0, -1);

        // Periodic 20-cycle stalls every 7 words, random addresses.
        cons_mode = 2;
        for (int t = 0; t < 2; t++) begin
            n = $urandom_range(1, 2);
            run_req($urandom_range(0, 1023), $urandom_range(0, 1023), n, $urandom_range(0, 255), 0, -1);
        end

        // Controller never ready: timeout after 100 idle cycles.
        cons_mode = 1;
        hung = 1;
        run_req(3, 1, 1, 0, 2, 101);
        check("tmo_no_rd", got_addr.size(), 0);
        hung = 0;

        // Abort at byte 300 of block 1, then a normal request.
        abort_arm = 1;
        run_req(1, 2, 2, $urandom_range(0, 255), 3, -1);
        check("abort_fired", abort_arm, 0);
        abort_arm = 0;
        run_req($urandom_range(0, 1023), $urandom_range(0, 1023), 1, $urandom_range(0, 255), 0, -1);

        // Zero-block request.
        run_req(4, 4, 0, 0, 0, -1);
        check("zero_words", word_cnt, 0);

        // Reset in the middle of a stream.
        start_req(7, 9, 1, $urandom_range(0, 255));
        dcnt = 0;
        while (cm_idx < 100 && dcnt < 5000) begin @(negedge CLOCK_50); dcnt++; end
        check("reach_stream", cm_idx >= 100, 1);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        check_reset_outputs("midreset");
        RESET = 1'b0;
        dcnt = 0;
        repeat (20) begin @(negedge CLOCK_50); if (app.done) dcnt++; end
        check("no_done_after_reset", dcnt, 0);
        exp_q.delete();

        run_req($urandom_range(0, 1023), $urandom_range(0, 1023), 1, $urandom_range(0, 255), 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
